// File: rtl/mem_write_checker.sv
// Store-stream self-check monitor: compares observed data-memory writes against
// an ordered table of expected (address, data) pairs and reports pass/fail/timeout.
module mem_write_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_EXPECT     = 8,
  parameter int TIMEOUT_CYCLES = 50,
  localparam int IW = (NUM_EXPECT > 1) ? $clog2(NUM_EXPECT) : 1,
  localparam int CW = $clog2(NUM_EXPECT) + 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] DataAdr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  cfg_we,
  input  logic [IW-1:0]         cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_addr_en,
  input  logic [CW-1:0]         cfg_count,
  input  logic                  strict,
  input  logic                  start,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [CW-1:0]         match_count,
  output logic [15:0]           write_count,
  output logic [TW-1:0]         cycle_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  logic [NUM_EXPECT-1:0][ADDR_WIDTH-1:0] tbl_addr;
  logic [NUM_EXPECT-1:0][DATA_WIDTH-1:0] tbl_data;
  logic [NUM_EXPECT-1:0]                 tbl_aen;
  logic [CW-1:0]         cnt_q;
  logic                  strict_q;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_aen;
  logic                  hit, bad_cfg, timeout;
  logic [CW-1:0]         mc_inc;
  logic [TW-1:0]         cc_inc;

  // Table is only writable while no run is in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_addr <= '0;
      tbl_data <= '0;
      tbl_aen  <= '0;
    end else if (cfg_we && state != RUN) begin
      for (int i = 0; i < NUM_EXPECT; i++) begin
        if (cfg_idx == IW'(i)) begin
          tbl_addr[i] <= cfg_addr;
          tbl_data[i] <= cfg_data;
          tbl_aen[i]  <= cfg_addr_en;
        end
      end
    end
  end

  // Entry currently expected, selected by the in-order match pointer.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_aen  = 1'b0;
    for (int i = 0; i < NUM_EXPECT; i++) begin
      if (match_count == CW'(i)) begin
        sel_addr = tbl_addr[i];
        sel_data = tbl_data[i];
        sel_aen  = tbl_aen[i];
      end
    end
  end

  assign hit     = MemWrite && (WriteData == sel_data) && (!sel_aen || DataAdr == sel_addr);
  assign bad_cfg = (cfg_count == '0) || (cfg_count > CW'(NUM_EXPECT));
  assign mc_inc  = match_count + CW'(1);
  assign cc_inc  = cycle_count + TW'(1);
  assign timeout = (cc_inc == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= 2'd0;
      match_count <= '0;
      write_count <= '0;
      cycle_count <= '0;
      cnt_q       <= '0;
      strict_q    <= 1'b0;
    end else if (start) begin
      pass        <= 1'b0;
      match_count <= '0;
      write_count <= '0;
      cycle_count <= '0;
      cnt_q       <= cfg_count;
      strict_q    <= strict;
      if (bad_cfg) begin
        state     <= DONE;
        done      <= 1'b1;
        fail_code <= 2'd3;
      end else begin
        state     <= RUN;
        done      <= 1'b0;
        fail_code <= 2'd0;
      end
    end else if (state == RUN) begin
      cycle_count <= cc_inc;
      if (MemWrite && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      if (hit) match_count <= mc_inc;
      // Final match beats timeout; a strict mismatch also beats timeout.
      if (hit && mc_inc == cnt_q) begin
        state <= DONE;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else if (MemWrite && !hit && strict_q) begin
        state     <= DONE;
        done      <= 1'b1;
        fail_code <= 2'd1;
      end else if (timeout) begin
        state     <= DONE;
        done      <= 1'b1;
        fail_code <= 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: vector table, hand sequences for multi-cycle
// corners, then random traffic against a run-level reference model.
module tb_mem_write_checker;
  localparam int N  = 8;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic        cfg_addr_en;
  logic [3:0]  cfg_count;
  logic        strict, start;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [3:0]  match_count;
  logic [15:0] write_count;
  logic [5:0]  cycle_count;

  int vectors = 0;
  int miscompares = 0;

  mem_write_checker dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_addr_en(cfg_addr_en), .cfg_count(cfg_count), .strict(strict), .start(start),
    .done(done), .pass(pass), .fail_code(fail_code), .match_count(match_count),
    .write_count(write_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Reference model: table contents plus the status of the current run.
  logic [31:0] m_addr [N];
  logic [31:0] m_data [N];
  bit          m_aen  [N];
  bit m_run, m_done, m_pass, m_strict;
  int m_fc, m_mc, m_wc, m_cc, m_cnt;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_addr[i] = 0; m_data[i] = 0; m_aen[i] = 0; end
    m_run = 0; m_done = 0; m_pass = 0; m_strict = 0;
    m_fc = 0; m_mc = 0; m_wc = 0; m_cc = 0; m_cnt = 0;
  endtask

  task automatic finish_run(bit p, int fc);
    m_run = 0; m_done = 1; m_pass = p; m_fc = fc;
  endtask

  task automatic model_step();
    bit hit;
    if (!reset) begin model_reset(); return; end
    if (cfg_we && !m_run) begin
      m_addr[cfg_idx] = cfg_addr; m_data[cfg_idx] = cfg_data; m_aen[cfg_idx] = cfg_addr_en;
    end
    if (start) begin
      m_wc = 0; m_cc = 0; m_mc = 0; m_pass = 0; m_fc = 0;
      m_cnt = int'(cfg_count); m_strict = strict;
      if (m_cnt < 1 || m_cnt > N) finish_run(0, 3);
      else begin m_run = 1; m_done = 0; end
    end else if (m_run) begin
      m_cc++;
      if (MemWrite && m_wc < 65535) m_wc++;
      hit = MemWrite && WriteData == m_data[m_mc] && (!m_aen[m_mc] || DataAdr == m_addr[m_mc]);
      if (hit) m_mc++;
      if (hit && m_mc == m_cnt) finish_run(1, 0);
      else if (MemWrite && !hit && m_strict) finish_run(0, 1);
      else if (m_cc == TO) finish_run(0, 2);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic e_done, logic e_pass, logic [1:0] e_fc,
                         logic [3:0] e_mc, logic [15:0] e_wc, logic [5:0] e_cc);
    chk({tag, ".done"},        32'(done),        32'(e_done));
    chk({tag, ".pass"},        32'(pass),        32'(e_pass));
    chk({tag, ".fail_code"},   32'(fail_code),   32'(e_fc));
    chk({tag, ".match_count"}, 32'(match_count), 32'(e_mc));
    chk({tag, ".write_count"}, 32'(write_count), 32'(e_wc));
    chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(e_cc));
  endtask

  task automatic idle_in();
    MemWrite = 0; DataAdr = 0; WriteData = 0; cfg_we = 0; cfg_idx = 0;
    cfg_addr = 0; cfg_data = 0; cfg_addr_en = 0; start = 0;
  endtask

  task automatic cfg_write(int idx, logic [31:0] a, logic [31:0] d, logic aen);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d; cfg_addr_en = aen;
    tick();
    cfg_we = 0;
  endtask

  task automatic arm(logic [3:0] cnt, logic s);
    start = 1; cfg_count = cnt; strict = s;
    tick();
    start = 0;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    MemWrite = 1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 0;
  endtask

  typedef struct {
    logic st; logic [3:0] cnt; logic strict; logic mw; logic [31:0] adr; logic [31:0] wd;
    logic e_done; logic e_pass; logic [1:0] e_fc; logic [3:0] e_mc; logic [15:0] e_wc;
  } vec_t;

  function automatic vec_t mk(logic st, logic [3:0] cnt, logic s, logic mw, logic [31:0] adr,
                              logic [31:0] wd, logic ed, logic ep, logic [1:0] efc,
                              logic [3:0] emc, logic [15:0] ewc);
    vec_t v;
    v.st = st; v.cnt = cnt; v.strict = s; v.mw = mw; v.adr = adr; v.wd = wd;
    v.e_done = ed; v.e_pass = ep; v.e_fc = efc; v.e_mc = emc; v.e_wc = ewc;
    return v;
  endfunction

  vec_t t1 [4];
  vec_t t2 [10];

  initial begin
    idle_in(); cfg_count = 0; strict = 0;
    reset = 0;
    model_reset();
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    #2 reset = 1;

    // Single entry, data only: store 5 ignored, store 7 matches.
    t1[0] = mk(1, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    t1[1] = mk(0, 1, 0, 1, 0,     5, 0, 0, 0, 0, 1);
    t1[2] = mk(0, 1, 0, 1, 0,     7, 1, 1, 0, 1, 2);
    t1[3] = mk(0, 1, 0, 0, 0,     0, 1, 1, 0, 1, 2);
    // Ordered pair with address check, swapped order, address-only mismatch, bad configs.
    t2[0] = mk(1, 2, 1, 0, 0,     0,     0, 0, 0, 0, 0);
    t2[1] = mk(0, 2, 1, 1, 32'h64, 7,     0, 0, 0, 1, 1);
    t2[2] = mk(0, 2, 1, 1, 32'h60, 32'h1A, 1, 1, 0, 2, 2);
    t2[3] = mk(1, 2, 1, 0, 0,     0,     0, 0, 0, 0, 0);
    t2[4] = mk(0, 2, 1, 1, 32'h60, 32'h1A, 1, 0, 1, 0, 1);
    t2[5] = mk(1, 2, 1, 0, 0,     0,     0, 0, 0, 0, 0);
    t2[6] = mk(0, 2, 1, 1, 32'h68, 7,     1, 0, 1, 0, 1);
    t2[7] = mk(1, 0, 0, 0, 0,     0,     1, 0, 3, 0, 0);
    t2[8] = mk(0, 0, 0, 1, 32'h64, 7,     1, 0, 3, 0, 0);
    t2[9] = mk(1, 9, 0, 0, 0,     0,     1, 0, 3, 0, 0);

    cfg_write(0, 0, 7, 0);
    for (int i = 0; i < 4; i++) begin
      start = t1[i].st; cfg_count = t1[i].cnt; strict = t1[i].strict;
      MemWrite = t1[i].mw; DataAdr = t1[i].adr; WriteData = t1[i].wd;
      tick();
      chk_all($sformatf("t1[%0d]", i), t1[i].e_done, t1[i].e_pass, t1[i].e_fc,
              t1[i].e_mc, t1[i].e_wc, 6'(m_cc));
    end
    idle_in();
    cfg_write(0, 32'h64, 7, 1);
    cfg_write(1, 32'h60, 32'h1A, 1);
    for (int i = 0; i < 10; i++) begin
      start = t2[i].st; cfg_count = t2[i].cnt; strict = t2[i].strict;
      MemWrite = t2[i].mw; DataAdr = t2[i].adr; WriteData = t2[i].wd;
      tick();
      chk($sformatf("t2[%0d].done", i), 32'(done), 32'(t2[i].e_done));
      chk($sformatf("t2[%0d].pass", i), 32'(pass), 32'(t2[i].e_pass));
      chk($sformatf("t2[%0d].fail_code", i), 32'(fail_code), 32'(t2[i].e_fc));
      chk($sformatf("t2[%0d].match_count", i), 32'(match_count), 32'(t2[i].e_mc));
      chk($sformatf("t2[%0d].write_count", i), 32'(write_count), 32'(t2[i].e_wc));
    end
    idle_in();

    // Timeout with no stores, then final match landing on the timeout cycle.
    cfg_write(0, 0, 32'h55, 0);
    arm(1, 0);
    repeat (TO - 1) tick();
    chk_all("to.pre", 0, 0, 0, 0, 0, 6'(TO - 1));
    tick();
    chk_all("to.hit", 1, 0, 2, 0, 0, 6'(TO));
    arm(1, 0);
    repeat (TO - 1) tick();
    store(0, 32'h55);
    chk_all("to.pass", 1, 1, 0, 1, 1, 6'(TO));

    // Reset mid-run clears everything; cleared entry 0 then matches data 0.
    cfg_write(0, 0, 1, 0);
    cfg_write(1, 0, 2, 0);
    arm(2, 1);
    store(0, 1);
    chk_all("rst.pre", 0, 0, 0, 1, 1, 1);
    reset = 0;
    model_reset();
    #1;
    chk_all("rst.async", 0, 0, 0, 0, 0, 0);
    #2 reset = 1;
    arm(1, 0);
    store(32'h1234, 0);
    chk_all("rst.rearm", 1, 1, 0, 1, 1, 1);

    // Config lockout during RUN, restart during RUN.
    cfg_write(0, 0, 9, 0);
    arm(1, 0);
    store(0, 3);
    chk_all("rs.run", 0, 0, 0, 0, 1, 1);
    cfg_write(0, 0, 32'h77, 0);
    arm(1, 0);
    chk_all("rs.restart", 0, 0, 0, 0, 0, 0);
    store(0, 32'h77);
    chk_all("rs.locked", 0, 0, 0, 0, 1, 1);
    store(0, 9);
    chk_all("rs.pass", 1, 1, 0, 1, 2, 2);

    // Random traffic with small value ranges so matches actually happen.
    for (int c = 0; c < 3000; c++) begin
      start       = ($urandom_range(0, 39) == 0);
      cfg_count   = 4'($urandom_range(0, 9));
      strict      = 1'($urandom_range(0, 1));
      MemWrite    = 1'($urandom_range(0, 1));
      DataAdr     = $urandom_range(0, 3);
      WriteData   = $urandom_range(0, 3);
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_idx     = 3'($urandom_range(0, 7));
      cfg_addr    = $urandom_range(0, 3);
      cfg_data    = $urandom_range(0, 3);
      cfg_addr_en = 1'($urandom_range(0, 1));
      tick();
      chk_all($sformatf("rnd%0d", c), m_done, m_pass, 2'(m_fc), 4'(m_mc), 16'(m_wc), 6'(m_cc));
    end
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

- Synthesizable self-check monitor for the processor `top`.
- Watches the data-memory write port (`MemWrite`, `DataAdr`, `WriteData`) and compares observed stores against a programmable table of expected (address, data) pairs.
- Reports pass, fail or timeout with status counters. It replaces the bench-only "single magic value" check with a configurable, multi-entry, cycle-bounded checker that also works in FPGA bring-up.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `WriteData` and expected data.
- `ADDR_WIDTH`, 32, width of `DataAdr` and expected address.
- `NUM_EXPECT`, 8, number of table entries; must be ≥ 1.
- `TIMEOUT_CYCLES`, 50, number of RUN cycles allowed before timeout; must be ≥ 1.

Ports (reset is asynchronous, active-low):
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  store strobe from `top`.
- `DataAdr`  in  ADDR_WIDTH  store address.
- `WriteData`  in  DATA_WIDTH  store data.
- `cfg_we`  in  1  table write strobe; honoured only in IDLE or DONE.
- `cfg_idx`  in  clog2(NUM_EXPECT)  table entry index.
- `cfg_addr`  in  ADDR_WIDTH  expected address.
- `cfg_data`  in  DATA_WIDTH  expected data.
- `cfg_addr_en`  in  1  compare the address for this entry (0 = data only).
- `cfg_count`  in  clog2(NUM_EXPECT)+1  number of entries that must match; latched on `start`.
- `strict`  in  1  a non-matching store causes FAIL (0 = ignore it); latched on `start`.
- `start`  in  1  one-cycle pulse that arms the checker.
- `done`  out  1  the checker is in DONE.
- `pass`  out  1  the run ended with all entries matched.
- `fail_code`  out  2  0 none, 1 mismatch, 2 timeout, 3 bad config.
- `match_count`  out  clog2(NUM_EXPECT)+1  entries matched so far.
- `write_count`  out  16  stores seen in RUN; saturates at 0xFFFF.
- `cycle_count`  out  clog2(TIMEOUT_CYCLES+1)  cycles spent in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset (`reset`=0):
  - State goes to IDLE.
  - All table entries clear to addr 0, data 0, addr_en 0.
  - All outputs are 0.
- IDLE:
  - `cfg_we` writes entry `cfg_idx`; indices ≥ NUM_EXPECT are ignored.
  - `start` moves to RUN: clears the counters and `fail_code`, and latches `cfg_count` and `strict`.
- `start` with `cfg_count`=0 or `cfg_count`>NUM_EXPECT:
  - Goes directly to DONE with `pass`=0 and `fail_code`=3.
- RUN: entries are matched in order, using pointer `match_count`.
  - Sampled store (`MemWrite`=1) matches when `WriteData`==entry.data and, if addr_en=1, `DataAdr`==entry.addr.
  - Match: `match_count` increments. If the new value equals `cfg_count`, go to DONE with `pass`=1.
  - No match and `strict`=1: go to DONE with `fail_code`=1.
  - No match and `strict`=0: the store is ignored.
  - Every sampled store increments `write_count`.
  - `cycle_count` increments every RUN cycle. When it reaches TIMEOUT_CYCLES, go to DONE with `fail_code`=2.
- Simultaneous events in the same cycle:
  - Final match and timeout: PASS wins.
  - Mismatch and timeout: `fail_code`=1.
- DONE:
  - Outputs hold until the next `start` or reset.
  - `cfg_we` is allowed.
  - `start` re-arms the checker as in IDLE.
- RUN and `start`:
  - `start` during RUN restarts the run, with counters cleared.
  - `cfg_we` during RUN is ignored.
- Reset asserted mid-run: the checker returns to IDLE immediately and the table is cleared.

## Timing
- Inputs are sampled on the rising `clk` edge. `top` drives the store signals from the same clock, so they are stable at the edge.
- `start` to RUN: 1 cycle. The first store that can be sampled is on the edge after the `start` edge.
- Store to status: `pass`, `done`, `fail_code` and `match_count` update on the edge that samples the store, so they are visible in the following cycle.
- Timeout: with `start` sampled at edge T, `done`=1 with `fail_code`=2 is visible after edge T+TIMEOUT_CYCLES.
- `done`, `pass` and `fail_code` are registered outputs with no combinational paths from the inputs.

## Test plan
1. Single entry.
   - Setup: cfg data=7, addr_en=0, cfg_count=1, strict=0, then `start`.
   - Stimulus: stores 5 then 7.
   - Required: `pass`=1, `done`=1, `match_count`=1, `write_count`=2, `fail_code`=0.
2. Ordered pair with address check.
   - Setup: entries {addr 0x64, data 7}, {addr 0x60, data 0x1A}, both addr_en=1, strict=1, cfg_count=2.
   - Stimulus: stores (0x64,7) then (0x60,0x1A).
   - Required: `pass`=1 after the second store.
   - Repeat with the order swapped: required `fail_code`=1 after the first store, `match_count`=0.
3. Timeout.
   - Setup: TIMEOUT_CYCLES=50, no stores.
   - Required: `done` rises exactly 50 cycles after `start`, with `fail_code`=2 and `cycle_count`=50.
   - Repeat with the final match on cycle 50: required `pass`=1, `fail_code`=0.
4. Bad config.
   - Stimulus: cfg_count=0, `start`.
   - Required: next cycle `done`=1, `fail_code`=3, and `write_count` stays 0 under stores.
5. Reset mid-run.
   - Stimulus: after 1 of 2 matches, pulse `reset` low.
   - Required: all outputs are 0 immediately.
   - Then: re-arm without reloading, using cfg_count=1 and a store of data 0. Required: `pass`=1, since the cleared table entry 0 is addr_en=0, data 0.
6. Restart and config lockout.
   - Stimulus: `cfg_we` during RUN, then `start` during RUN.
   - Required: the table is unchanged, and counters return to 0 on the cycle after `start`.
